// File: rtl/rob_commit_ctrl_pkg.sv
// Shared configuration for the ROB commit controller: id width, table size,
// field widths, the reserved "not renamed" id and the pointer-advance helper.
package rob_commit_ctrl_pkg;

    localparam int ROB_LOG  = 4;
    localparam int ROB_SIZE = 1 << ROB_LOG;
    localparam int RD_W     = 5;
    localparam int XLEN     = 32;

    typedef logic [ROB_LOG-1:0] rob_id_t;
    typedef logic [RD_W-1:0]    rd_t;
    typedef logic [XLEN-1:0]    word_t;

    // Id 0 means "not renamed" to the register file and is never handed out.
    localparam rob_id_t ROB_ID_NONE  = '0;
    localparam rob_id_t ROB_ID_FIRST = rob_id_t'(1);
    localparam rob_id_t ROB_ID_LAST  = rob_id_t'(ROB_SIZE - 1);

    // RUN: normal issue/commit. FLUSH: the one cycle jump_flag is high.
    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } rob_state_e;

    // Advance a ROB pointer, wrapping from the last id back to 1 (skipping 0).
    function automatic rob_id_t rob_id_next(input rob_id_t id);
        return (id == ROB_ID_LAST) ? ROB_ID_FIRST : id + rob_id_t'(1);
    endfunction

endpackage

// File: rtl/rob_commit_ctrl_if.sv
// Bus bundle between the ROB and decoder/CDB/RegFile. The slave modport is the
// ROB side; master is the environment (decoder, CDB, RegFile or a bench).
// Handshake: issue is accepted in a cycle exactly when rename_valid is high
// (issue_valid held by the source until then); wb_valid and commit_valid are
// single-cycle strobes with no back-pressure; jump_flag is a one-cycle pulse.
// dbg_* mirror the internal state register and pointers for observation.
interface rob_commit_ctrl_if;
    import rob_commit_ctrl_pkg::*;

    logic       issue_valid;
    rd_t        issue_rd_in;
    word_t      issue_pc;
    logic       issue_is_br;
    logic       rob_full;
    logic       rename_valid;
    rd_t        issue_rd;
    rob_id_t    issue_RobId;

    logic       wb_valid;
    rob_id_t    wb_RobId;
    word_t      wb_value;
    logic       wb_jump;
    word_t      wb_target;

    rob_id_t    query_RobId;
    logic       query_ready;
    word_t      query_value;

    logic       commit_valid;
    rd_t        commit_dest;
    word_t      commit_value;
    rob_id_t    commit_RobId;

    logic       jump_flag;
    word_t      jump_pc;

    rob_state_e dbg_state;
    rob_id_t    dbg_head;
    rob_id_t    dbg_tail;
    rob_id_t    dbg_count;

    modport slave (
        input  issue_valid, issue_rd_in, issue_pc, issue_is_br,
        input  wb_valid, wb_RobId, wb_value, wb_jump, wb_target,
        input  query_RobId,
        output rob_full, rename_valid, issue_rd, issue_RobId,
        output query_ready, query_value,
        output commit_valid, commit_dest, commit_value, commit_RobId,
        output jump_flag, jump_pc,
        output dbg_state, dbg_head, dbg_tail, dbg_count
    );

    modport master (
        output issue_valid, issue_rd_in, issue_pc, issue_is_br,
        output wb_valid, wb_RobId, wb_value, wb_jump, wb_target,
        output query_RobId,
        input  rob_full, rename_valid, issue_rd, issue_RobId,
        input  query_ready, query_value,
        input  commit_valid, commit_dest, commit_value, commit_RobId,
        input  jump_flag, jump_pc,
        input  dbg_state, dbg_head, dbg_tail, dbg_count
    );

endinterface

// File: rtl/rob_commit_ctrl_entry_store.sv
// Per-entry ROB storage: occupancy/ready bits plus rd, branch flag, value,
// mispredict flag and redirect target. One allocate port, one writeback port,
// one commit-release port, a flush that empties everything, and two read
// ports (head and operand query). Writebacks to unoccupied ids are dropped.
// The instruction pc is not kept: the redirect target comes from the CDB.
module rob_commit_ctrl_entry_store
    import rob_commit_ctrl_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    i_flush,
    input  logic    i_alloc_we,
    input  rob_id_t i_alloc_id,
    input  rd_t     i_alloc_rd,
    input  logic    i_alloc_is_br,
    input  logic    i_wb_we,
    input  rob_id_t i_wb_id,
    input  word_t   i_wb_value,
    input  logic    i_wb_jump,
    input  word_t   i_wb_target,
    input  logic    i_commit_we,
    input  rob_id_t i_commit_id,
    input  rob_id_t i_head_id,
    output logic    o_head_ready,
    output rd_t     o_head_rd,
    output word_t   o_head_value,
    output logic    o_head_jump,
    output word_t   o_head_target,
    input  rob_id_t i_query_id,
    output logic    o_query_ready,
    output word_t   o_query_value
);

    logic [ROB_SIZE-1:0] r_valid;
    logic [ROB_SIZE-1:0] r_ready;
    logic [ROB_SIZE-1:0] r_is_br;
    logic [ROB_SIZE-1:0] r_jump;
    rd_t                 r_rd     [ROB_SIZE];
    word_t               r_value  [ROB_SIZE];
    word_t               r_target [ROB_SIZE];

    logic w_wb_hit;

    assign w_wb_hit = i_wb_we && r_valid[i_wb_id];

    // Occupancy and ready bits: reset/flush empty the table, allocation wins
    // over a writeback to the same slot (the slot cannot be occupied then).
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_valid <= '0;
            r_ready <= '0;
        end else begin
            if (i_commit_we) begin
                r_valid[i_commit_id] <= 1'b0;
            end
            if (w_wb_hit) begin
                r_ready[i_wb_id] <= 1'b1;
            end
            if (i_alloc_we) begin
                r_valid[i_alloc_id] <= 1'b1;
                r_ready[i_alloc_id] <= 1'b0;
            end
        end
    end

    // Payload fields: no reset needed, they are only read behind ready bits.
    always_ff @(posedge clk) begin
        if (!rst && !i_flush) begin
            if (w_wb_hit) begin
                r_value[i_wb_id]  <= i_wb_value;
                r_jump[i_wb_id]   <= i_wb_jump;
                r_target[i_wb_id] <= i_wb_target;
            end
            if (i_alloc_we) begin
                r_rd[i_alloc_id]    <= i_alloc_rd;
                r_is_br[i_alloc_id] <= i_alloc_is_br;
                r_jump[i_alloc_id]  <= 1'b0;
            end
        end
    end

    assign o_head_ready  = r_ready[i_head_id];
    assign o_head_rd     = r_rd[i_head_id];
    assign o_head_value  = r_value[i_head_id];
    assign o_head_jump   = r_jump[i_head_id] & r_is_br[i_head_id];
    assign o_head_target = r_target[i_head_id];
    assign o_query_ready = r_ready[i_query_id];
    assign o_query_value = r_value[i_query_id];

endmodule

// File: rtl/rob_commit_ctrl.sv
// Reorder-buffer sequencer: allocates ids 1..2^ROB_LOG-1 at issue, collects
// CDB writebacks, retires in order (zero-latency combinational commit) and
// raises a registered one-cycle jump_flag after a mispredicted branch commits.
// Optional macro ROB_WB_BYPASS_EN: operand query also sees a same-cycle CDB
// writeback; without it the query returns stored state only.
module rob_commit_ctrl
    import rob_commit_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    rob_commit_ctrl_if.slave  bus
);

    rob_state_e r_state;
    rob_state_e w_state_next;
    rob_id_t    r_head;
    rob_id_t    r_tail;
    rob_id_t    r_count;
    word_t      r_jump_pc;

    logic    w_jump_flag;
    logic    w_rob_full;
    logic    w_alloc;
    logic    w_commit;
    logic    w_wb_we;
    logic    w_flush;
    logic    w_head_ready;
    rd_t     w_head_rd;
    word_t   w_head_value;
    logic    w_head_jump;
    word_t   w_head_target;
    logic    w_q_ready;
    word_t   w_q_value;

    assign w_jump_flag = (r_state == ST_FLUSH);
    // Full is taken from the count register only, so a same-cycle commit
    // never frees a slot for the issue in that cycle.
    assign w_rob_full  = (r_count == ROB_ID_LAST);
    assign w_alloc     = rdy && bus.issue_valid && !w_rob_full && !w_jump_flag;
    assign w_commit    = rdy && !w_jump_flag && (r_count != ROB_ID_NONE) && w_head_ready;
    assign w_wb_we     = rdy && !w_jump_flag && bus.wb_valid;
    assign w_flush     = rdy && w_jump_flag;

    rob_commit_ctrl_entry_store u_store (
        .clk           (clk),
        .rst           (rst),
        .i_flush       (w_flush),
        .i_alloc_we    (w_alloc),
        .i_alloc_id    (r_tail),
        .i_alloc_rd    (bus.issue_rd_in),
        .i_alloc_is_br (bus.issue_is_br),
        .i_wb_we       (w_wb_we),
        .i_wb_id       (bus.wb_RobId),
        .i_wb_value    (bus.wb_value),
        .i_wb_jump     (bus.wb_jump),
        .i_wb_target   (bus.wb_target),
        .i_commit_we   (w_commit),
        .i_commit_id   (r_head),
        .i_head_id     (r_head),
        .o_head_ready  (w_head_ready),
        .o_head_rd     (w_head_rd),
        .o_head_value  (w_head_value),
        .o_head_jump   (w_head_jump),
        .o_head_target (w_head_target),
        .i_query_id    (bus.query_RobId),
        .o_query_ready (w_q_ready),
        .o_query_value (w_q_value)
    );

    // Flush state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state: a mispredicted head commit enters FLUSH for exactly one
    // enabled cycle; rdy low holds the current state.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_RUN: begin
                if (w_commit && w_head_jump) begin
                    w_state_next = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (rdy) begin
                    w_state_next = ST_RUN;
                end
            end
            default: w_state_next = ST_RUN;
        endcase
    end

    // Pointers, occupancy count and redirect target.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head    <= ROB_ID_FIRST;
            r_tail    <= ROB_ID_FIRST;
            r_count   <= ROB_ID_NONE;
            r_jump_pc <= '0;
        end else if (w_flush) begin
            r_head  <= ROB_ID_FIRST;
            r_tail  <= ROB_ID_FIRST;
            r_count <= ROB_ID_NONE;
        end else begin
            if (w_alloc) begin
                r_tail <= rob_id_next(r_tail);
            end
            if (w_commit) begin
                r_head <= rob_id_next(r_head);
            end
            if (w_alloc && !w_commit) begin
                r_count <= r_count + rob_id_t'(1);
            end else if (!w_alloc && w_commit) begin
                r_count <= r_count - rob_id_t'(1);
            end
            if (w_commit && w_head_jump) begin
                r_jump_pc <= w_head_target;
            end
        end
    end

`ifdef ROB_WB_BYPASS_EN
    // Operand query with same-cycle CDB forwarding.
    always_comb begin
        bus.query_ready = w_q_ready;
        bus.query_value = w_q_value;
        if (bus.wb_valid && (bus.wb_RobId == bus.query_RobId)) begin
            bus.query_ready = 1'b1;
            bus.query_value = bus.wb_value;
        end
    end
`else
    assign bus.query_ready = w_q_ready;
    assign bus.query_value = w_q_value;
`endif

    assign bus.rob_full     = w_rob_full;
    assign bus.rename_valid = w_alloc;
    assign bus.issue_rd     = bus.issue_rd_in;
    assign bus.issue_RobId  = r_tail;
    assign bus.commit_valid = w_commit;
    assign bus.commit_dest  = w_head_rd;
    assign bus.commit_value = w_head_value;
    assign bus.commit_RobId = r_head;
    assign bus.jump_flag    = w_jump_flag;
    assign bus.jump_pc      = r_jump_pc;
    assign bus.dbg_state    = r_state;
    assign bus.dbg_head     = r_head;
    assign bus.dbg_tail     = r_tail;
    assign bus.dbg_count    = r_count;

endmodule

// File: tb/tb_rob_commit_ctrl.sv
// Directed bench for rob_commit_ctrl: issue/rename, in-order commit, query
// bypass, full/wrap, mispredict flush and rdy hold. Inputs change 2 time units
// after the rising edge; outputs are checked 1 unit later.
module tb_rob_commit_ctrl;
    import rob_commit_ctrl_pkg::*;

`ifdef ROB_WB_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic clk;
    logic rst;
    logic rdy;
    int   n_tests;
    int   n_fail;

    rob_commit_ctrl_if bus ();

    rob_commit_ctrl dut (
        .clk (clk),
        .rst (rst),
        .rdy (rdy),
        .bus (bus)
    );

    // Clock and watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive_idle();
        bus.issue_valid = 1'b0;
        bus.issue_rd_in = '0;
        bus.issue_pc    = '0;
        bus.issue_is_br = 1'b0;
        bus.wb_valid    = 1'b0;
        bus.wb_RobId    = '0;
        bus.wb_value    = '0;
        bus.wb_jump     = 1'b0;
        bus.wb_target   = '0;
        bus.query_RobId = '0;
    endtask

    task automatic drive_issue(input logic [4:0] rd, input logic is_br);
        bus.issue_valid = 1'b1;
        bus.issue_rd_in = rd;
        bus.issue_pc    = {25'd0, rd, 2'b00};
        bus.issue_is_br = is_br;
    endtask

    task automatic drive_wb(input logic [3:0] id, input logic [31:0] val,
                            input logic jump, input logic [31:0] tgt);
        bus.wb_valid  = 1'b1;
        bus.wb_RobId  = id;
        bus.wb_value  = val;
        bus.wb_jump   = jump;
        bus.wb_target = tgt;
    endtask

    task automatic reset_dut();
        drive_idle();
        rdy = 1'b1;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    // Scenario tasks
    task automatic test_reset();
        reset_dut();
        n_tests++; if (bus.dbg_head !== 4'd1) begin n_fail++; $display("FAIL reset_head got=%0d exp=1", bus.dbg_head); end
        n_tests++; if (bus.dbg_tail !== 4'd1) begin n_fail++; $display("FAIL reset_tail got=%0d exp=1", bus.dbg_tail); end
        n_tests++; if (bus.dbg_count !== 4'd0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", bus.dbg_count); end
        n_tests++; if (bus.rob_full !== 1'b0) begin n_fail++; $display("FAIL reset_full got=%b exp=0", bus.rob_full); end
        n_tests++; if (bus.commit_valid !== 1'b0) begin n_fail++; $display("FAIL reset_commit got=%b exp=0", bus.commit_valid); end
        n_tests++; if (bus.jump_flag !== 1'b0) begin n_fail++; $display("FAIL reset_jump_flag got=%b exp=0", bus.jump_flag); end
        n_tests++; if (bus.jump_pc !== 32'd0) begin n_fail++; $display("FAIL reset_jump_pc got=%0h exp=0", bus.jump_pc); end
    endtask

    task automatic test_issue();
        logic [3:0] exp_id;
        for (int i = 1; i <= 3; i++) begin
            exp_id = 4'(i);
            drive_issue(5'(i), 1'b0);
            #1;
            n_tests++; if (bus.rename_valid !== 1'b1) begin n_fail++; $display("FAIL issue_rename[%0d] got=%b exp=1", i, bus.rename_valid); end
            n_tests++; if (bus.issue_RobId !== exp_id) begin n_fail++; $display("FAIL issue_id[%0d] got=%0d exp=%0d", i, bus.issue_RobId, exp_id); end
            n_tests++; if (bus.issue_rd !== 5'(i)) begin n_fail++; $display("FAIL issue_rd[%0d] got=%0d exp=%0d", i, bus.issue_rd, i); end
            n_tests++; if (bus.rob_full !== 1'b0) begin n_fail++; $display("FAIL issue_full[%0d] got=%b exp=0", i, bus.rob_full); end
            tick();
        end
        drive_idle();
        #1;
        n_tests++; if (bus.dbg_count !== 4'd3) begin n_fail++; $display("FAIL issue_count got=%0d exp=3", bus.dbg_count); end
        n_tests++; if (bus.dbg_tail !== 4'd4) begin n_fail++; $display("FAIL issue_tail got=%0d exp=4", bus.dbg_tail); end
    endtask

    task automatic test_inorder_commit();
        drive_wb(4'd2, 32'h22, 1'b0, 32'h0);
        #1;
        n_tests++; if (bus.commit_valid !== 1'b0) begin n_fail++; $display("FAIL ooo_no_commit got=%b exp=0", bus.commit_valid); end
        tick();
        drive_wb(4'd1, 32'h11, 1'b0, 32'h0);
        #1;
        n_tests++; if (bus.commit_valid !== 1'b0) begin n_fail++; $display("FAIL wb_head_same_cycle got=%b exp=0", bus.commit_valid); end
        tick();
        drive_idle();
        #1;
        n_tests++; if (bus.commit_valid !== 1'b1) begin n_fail++; $display("FAIL commit1_valid got=%b exp=1", bus.commit_valid); end
        n_tests++; if (bus.commit_RobId !== 4'd1) begin n_fail++; $display("FAIL commit1_id got=%0d exp=1", bus.commit_RobId); end
        n_tests++; if (bus.commit_dest !== 5'd1) begin n_fail++; $display("FAIL commit1_dest got=%0d exp=1", bus.commit_dest); end
        n_tests++; if (bus.commit_value !== 32'h11) begin n_fail++; $display("FAIL commit1_value got=%0h exp=11", bus.commit_value); end
        tick();
        #1;
        n_tests++; if (bus.commit_valid !== 1'b1) begin n_fail++; $display("FAIL commit2_valid got=%b exp=1", bus.commit_valid); end
        n_tests++; if (bus.commit_RobId !== 4'd2) begin n_fail++; $display("FAIL commit2_id got=%0d exp=2", bus.commit_RobId); end
        n_tests++; if (bus.commit_dest !== 5'd2) begin n_fail++; $display("FAIL commit2_dest got=%0d exp=2", bus.commit_dest); end
        n_tests++; if (bus.commit_value !== 32'h22) begin n_fail++; $display("FAIL commit2_value got=%0h exp=22", bus.commit_value); end
        tick();
        #1;
        n_tests++; if (bus.commit_valid !== 1'b0) begin n_fail++; $display("FAIL commit3_not_ready got=%b exp=0", bus.commit_valid); end
        n_tests++; if (bus.dbg_head !== 4'd3) begin n_fail++; $display("FAIL commit_head got=%0d exp=3", bus.dbg_head); end
        n_tests++; if (bus.dbg_count !== 4'd1) begin n_fail++; $display("FAIL commit_count got=%0d exp=1", bus.dbg_count); end
    endtask

    task automatic test_query_bypass();
        drive_wb(4'd3, 32'h33, 1'b0, 32'h0);
        bus.query_RobId = 4'd3;
        #1;
        n_tests++; if (bus.query_ready !== BYPASS) begin n_fail++; $display("FAIL query_same_cycle_ready got=%b exp=%b", bus.query_ready, BYPASS); end
        if (BYPASS) begin
            n_tests++; if (bus.query_value !== 32'h33) begin n_fail++; $display("FAIL query_same_cycle_value got=%0h exp=33", bus.query_value); end
        end
        tick();
        bus.wb_valid = 1'b0;
        #1;
        n_tests++; if (bus.query_ready !== 1'b1) begin n_fail++; $display("FAIL query_stored_ready got=%b exp=1", bus.query_ready); end
        n_tests++; if (bus.query_value !== 32'h33) begin n_fail++; $display("FAIL query_stored_value got=%0h exp=33", bus.query_value); end
        n_tests++; if (bus.commit_valid !== 1'b1 || bus.commit_RobId !== 4'd3) begin n_fail++; $display("FAIL commit_id3 got=%b/%0d exp=1/3", bus.commit_valid, bus.commit_RobId); end
        tick();
        drive_idle();
        #1;
        n_tests++; if (bus.dbg_count !== 4'd0) begin n_fail++; $display("FAIL drain_count got=%0d exp=0", bus.dbg_count); end
    endtask

    task automatic test_full_wrap();
        logic [3:0] exp_id;
        reset_dut();
        for (int i = 0; i < 15; i++) begin
            exp_id = 4'(i + 1);
            drive_issue(5'(i + 1), 1'b0);
            #1;
            n_tests++; if (bus.rename_valid !== 1'b1 || bus.issue_RobId !== exp_id) begin n_fail++; $display("FAIL fill[%0d] got=%b/%0d exp=1/%0d", i, bus.rename_valid, bus.issue_RobId, exp_id); end
            tick();
        end
        drive_wb(4'd1, 32'hA1, 1'b0, 32'h0);
        #1;
        n_tests++; if (bus.rob_full !== 1'b1) begin n_fail++; $display("FAIL full_flag got=%b exp=1", bus.rob_full); end
        n_tests++; if (bus.dbg_count !== 4'd15) begin n_fail++; $display("FAIL full_count got=%0d exp=15", bus.dbg_count); end
        n_tests++; if (bus.rename_valid !== 1'b0) begin n_fail++; $display("FAIL issue16_blocked got=%b exp=0", bus.rename_valid); end
        tick();
        bus.wb_valid = 1'b0;
        #1;
        n_tests++; if (bus.commit_valid !== 1'b1 || bus.commit_value !== 32'hA1) begin n_fail++; $display("FAIL full_commit got=%b/%0h exp=1/a1", bus.commit_valid, bus.commit_value); end
        n_tests++; if (bus.rename_valid !== 1'b0) begin n_fail++; $display("FAIL full_commit_blocks_issue got=%b exp=0", bus.rename_valid); end
        tick();
        #1;
        n_tests++; if (bus.rob_full !== 1'b0) begin n_fail++; $display("FAIL after_commit_full got=%b exp=0", bus.rob_full); end
        n_tests++; if (bus.rename_valid !== 1'b1 || bus.issue_RobId !== 4'd1) begin n_fail++; $display("FAIL wrap_id got=%b/%0d exp=1/1", bus.rename_valid, bus.issue_RobId); end
        tick();
        drive_idle();
        #1;
        n_tests++; if (bus.dbg_tail !== 4'd2 || bus.dbg_count !== 4'd15) begin n_fail++; $display("FAIL wrap_ptrs got=%0d/%0d exp=2/15", bus.dbg_tail, bus.dbg_count); end
    endtask

    task automatic test_mispredict();
        reset_dut();
        for (int i = 1; i <= 6; i++) begin
            drive_issue(5'(i), (i == 4));
            tick();
        end
        drive_idle();
        drive_wb(4'd5, 32'h55, 1'b0, 32'h0);
        tick();
        drive_wb(4'd6, 32'h66, 1'b0, 32'h0);
        tick();
        drive_wb(4'd1, 32'h11, 1'b0, 32'h0);
        #1;
        n_tests++; if (bus.commit_valid !== 1'b0) begin n_fail++; $display("FAIL br_young_ready_no_commit got=%b exp=0", bus.commit_valid); end
        tick();
        drive_wb(4'd2, 32'h12, 1'b0, 32'h0);
        #1;
        n_tests++; if (bus.commit_valid !== 1'b1 || bus.commit_RobId !== 4'd1) begin n_fail++; $display("FAIL br_commit1 got=%b/%0d exp=1/1", bus.commit_valid, bus.commit_RobId); end
        tick();
        drive_wb(4'd3, 32'h13, 1'b0, 32'h0);
        tick();
        drive_wb(4'd4, 32'h44, 1'b1, 32'h1000);
        #1;
        n_tests++; if (bus.commit_valid !== 1'b1 || bus.commit_RobId !== 4'd3) begin n_fail++; $display("FAIL br_commit3 got=%b/%0d exp=1/3", bus.commit_valid, bus.commit_RobId); end
        tick();
        drive_idle();
        #1;
        n_tests++; if (bus.commit_valid !== 1'b1 || bus.commit_RobId !== 4'd4) begin n_fail++; $display("FAIL br_commit4 got=%b/%0d exp=1/4", bus.commit_valid, bus.commit_RobId); end
        n_tests++; if (bus.commit_dest !== 5'd4 || bus.commit_value !== 32'h44) begin n_fail++; $display("FAIL br_link got=%0d/%0h exp=4/44", bus.commit_dest, bus.commit_value); end
        n_tests++; if (bus.jump_flag !== 1'b0) begin n_fail++; $display("FAIL br_flag_early got=%b exp=0", bus.jump_flag); end
        tick();
        drive_issue(5'd7, 1'b0);
        #1;
        n_tests++; if (bus.jump_flag !== 1'b1) begin n_fail++; $display("FAIL br_flag got=%b exp=1", bus.jump_flag); end
        n_tests++; if (bus.jump_pc !== 32'h1000) begin n_fail++; $display("FAIL br_jump_pc got=%0h exp=1000", bus.jump_pc); end
        n_tests++; if (bus.commit_valid !== 1'b0) begin n_fail++; $display("FAIL br_flush_commit got=%b exp=0", bus.commit_valid); end
        n_tests++; if (bus.rename_valid !== 1'b0) begin n_fail++; $display("FAIL br_flush_rename got=%b exp=0", bus.rename_valid); end
        tick();
        #1;
        n_tests++; if (bus.jump_flag !== 1'b0) begin n_fail++; $display("FAIL br_flag_pulse got=%b exp=0", bus.jump_flag); end
        n_tests++; if (bus.dbg_head !== 4'd1 || bus.dbg_count !== 4'd0) begin n_fail++; $display("FAIL br_ptrs got=%0d/%0d exp=1/0", bus.dbg_head, bus.dbg_count); end
        n_tests++; if (bus.commit_valid !== 1'b0) begin n_fail++; $display("FAIL br_young_squashed got=%b exp=0", bus.commit_valid); end
        n_tests++; if (bus.rename_valid !== 1'b1 || bus.issue_RobId !== 4'd1) begin n_fail++; $display("FAIL br_reissue_id got=%b/%0d exp=1/1", bus.rename_valid, bus.issue_RobId); end
        tick();
        drive_idle();
    endtask

    task automatic test_rdy_hold();
        drive_wb(4'd1, 32'h77, 1'b0, 32'h0);
        tick();
        drive_idle();
        rdy = 1'b0;
        drive_issue(5'd9, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            n_tests++; if (bus.commit_valid !== 1'b0 || bus.rename_valid !== 1'b0) begin n_fail++; $display("FAIL rdy_low_outs[%0d] got=%b/%b exp=0/0", i, bus.commit_valid, bus.rename_valid); end
            tick();
            n_tests++; if (bus.dbg_head !== 4'd1 || bus.dbg_tail !== 4'd2 || bus.dbg_count !== 4'd1) begin n_fail++; $display("FAIL rdy_low_ptrs[%0d] got=%0d/%0d/%0d exp=1/2/1", i, bus.dbg_head, bus.dbg_tail, bus.dbg_count); end
        end
        drive_idle();
        rdy = 1'b1;
        #1;
        n_tests++; if (bus.commit_valid !== 1'b1 || bus.commit_value !== 32'h77) begin n_fail++; $display("FAIL rdy_resume got=%b/%0h exp=1/77", bus.commit_valid, bus.commit_value); end
        tick();
        #1;
        n_tests++; if (bus.dbg_count !== 4'd0 || bus.dbg_head !== 4'd2) begin n_fail++; $display("FAIL rdy_resume_ptrs got=%0d/%0d exp=0/2", bus.dbg_count, bus.dbg_head); end
    endtask

    // Sequencer and final report
    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b1;
        rdy     = 1'b1;
        drive_idle();
        test_reset();
        test_issue();
        test_inorder_commit();
        test_query_bypass();
        test_full_wrap();
        test_mispredict();
        test_rdy_hold();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
